// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU among NUM_REQ requesters. Each cycle one valid
// request is selected (round-robin by default) and its operands/opcode are
// registered into the issue stage (S1), which drives the ALU directly. The ALU
// result and flags are captured into the response stage (S2) and returned with
// the winning requester's index under valid/ready handshaking.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest asserted index wins
//                          undefined -> round-robin starting at prio_ptr
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid / req_ready        per-requester handshake (at most one ready high)
//   req_a, req_b                 packed operands, requester i at [32*i +: 32]
//   req_ctrl                     packed opcodes, requester i at [4*i +: 4]
//   alu_a, alu_b, alu_ctrl       issue registers feeding the shared ALU
//   alu_result, alu_zero/lt/ge   ALU outputs, sampled into the response stage
//   rsp_valid / rsp_ready        response handshake
//   rsp_id, rsp_result, rsp_*    captured response fields
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*4-1:0] req_ctrl,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_ctrl,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 alu_ge,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_lt,
    output logic                 rsp_ge
);

    localparam logic [ID_W:0]   NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_REQ - 1);

    // Unpacked views of the packed request buses.
    logic [31:0] a_arr    [NUM_REQ];
    logic [31:0] b_arr    [NUM_REQ];
    logic [3:0]  ctrl_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]    = req_a[32*gi +: 32];
            assign b_arr[gi]    = req_b[32*gi +: 32];
            assign ctrl_arr[gi] = req_ctrl[4*gi +: 4];
        end
    endgenerate

    logic            s1_valid_reg;
    logic [ID_W-1:0] s1_id_reg;
    logic [ID_W-1:0] prio_ptr;
    logic            s2_free;
    logic            s1_free;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   scan_idx;
    logic            accept;

    assign s2_free = ~rsp_valid | rsp_ready;
    // Gated with rst_n so req_ready reads 0 while reset is held, even though
    // S1 is empty during reset.
    assign s1_free = (~s1_valid_reg | s2_free) & rst_n;

    // Scan requesters starting at prio_ptr, wrapping modulo NUM_REQ; the first
    // valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, prio_ptr} + (ID_W+1)'(k);
            if (scan_idx >= NUM_REQ_EXT) begin
                scan_idx = scan_idx - NUM_REQ_EXT;
            end
            if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_id] = s1_free;
        end
    end

    assign accept = grant_found & s1_free;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign prio_ptr = '0;
`else
    logic [ID_W-1:0] prio_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr_reg <= '0;
        end else if (accept) begin
            prio_ptr_reg <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
        end
    end

    assign prio_ptr = prio_ptr_reg;
`endif

    // Issue stage: data is only loaded on accept, so an emptied S1 keeps its
    // last operands on the ALU inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_ctrl     <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_id_reg    <= grant_id;
            alu_a        <= a_arr[grant_id];
            alu_b        <= b_arr[grant_id];
            alu_ctrl     <= ctrl_arr[grant_id];
        end else if (s2_free) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Response stage: fields hold while rsp_valid & ~rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_ge     <= 1'b0;
        end else if (s2_free) begin
            rsp_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                rsp_id     <= s1_id_reg;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_lt     <= alu_lt;
                rsp_ge     <= alu_ge;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter (NUM_REQ=2) with a behavioural ALU attached
// to the issue registers. Honours ALU_ARB_FIXED_PRIO_EN for the contention
// expectations.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*4-1:0] req_ctrl;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [3:0]           alu_ctrl;
    logic [31:0]          alu_result;
    logic                 alu_zero;
    logic                 alu_lt;
    logic                 alu_ge;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_result;
    logic                 rsp_zero;
    logic                 rsp_lt;
    logic                 rsp_ge;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .alu_ge     (alu_ge),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_lt     (rsp_lt),
        .rsp_ge     (rsp_ge)
    );

    // Behavioural shared ALU.
    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = alu_a << alu_b[4:0];
            4'd6:    alu_result = alu_a >> alu_b[4:0];
            4'd7:    alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'd8:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd9:    alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_lt   = $signed(alu_a) < $signed(alu_b);
        alu_ge   = ~alu_lt;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_ctrl[4*i +: 4] = c;
    endtask

    initial begin
        int exp_g [8];
        logic [31:0] exp_res [3];
        logic [31:0] a_cur;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;

        // ---- reset state ----
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- single op: 5 - 3 on requester 0 ----
        set_req(0, 32'd5, 32'd3, 4'd1);
        req_valid = 2'b01;
        #1;
        chk("single_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd3);
        chk("single_alu_ctrl", 32'(alu_ctrl), 32'd1);
        chk("single_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd0);
        chk("single_result", rsp_result, 32'd2);
        chk("single_zero", 32'(rsp_zero), 32'd0);
        chk("single_lt", 32'(rsp_lt), 32'd0);
        chk("single_ge", 32'(rsp_ge), 32'd1);
        tick();
        chk("single_rsp_pop", 32'(rsp_valid), 32'd0);

        // ---- SLT signed compare on requester 1 ----
        set_req(1, 32'hFFFF_FFFF, 32'd1, 4'd8);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        chk("slt_rsp_id", 32'(rsp_id), 32'd1);
        chk("slt_result", rsp_result, 32'd1);
        chk("slt_lt", 32'(rsp_lt), 32'd1);
        chk("slt_ge", 32'(rsp_ge), 32'd0);
        tick();

        // ---- SLTU, same operands, on requester 0 ----
        set_req(0, 32'hFFFF_FFFF, 32'd1, 4'd9);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("sltu_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("sltu_result", rsp_result, 32'd0);
        tick();

        // ---- contention from reset: both requesters issue ADD continuously ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g[i] = 0;
`else
            exp_g[i] = i % 2;
`endif
        end
        set_req(0, 32'd10, 32'd1, 4'd0);
        set_req(1, 32'd20, 32'd2, 4'd0);
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(1 << exp_g[i]));
            if (i >= 2) begin
                chk($sformatf("rr_rsp_valid_%0d", i), 32'(rsp_valid), 32'd1);
                chk($sformatf("rr_rsp_id_%0d", i), 32'(rsp_id), 32'(exp_g[i-2]));
                chk($sformatf("rr_result_%0d", i), rsp_result,
                    (exp_g[i-2] == 1) ? 32'd22 : 32'd11);
            end
            tick();
        end
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

        // ---- backpressure: rsp_ready low for 5 cycles, req 0 continuous ----
        rsp_ready = 1'b0;
        a_cur = 32'd100;
        set_req(0, a_cur, 32'd1, 4'd0);
        req_valid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_ready_%0d", c), 32'(req_ready), (c < 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk($sformatf("bp_hold_valid_%0d", c), 32'(rsp_valid), 32'd1);
                chk($sformatf("bp_hold_result_%0d", c), rsp_result, 32'd101);
            end
            tick();
            if (c < 2) begin
                a_cur = a_cur + 32'd1;
                set_req(0, a_cur, 32'd1, 4'd0);
            end
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        exp_res[0] = 32'd101;
        exp_res[1] = 32'd102;
        exp_res[2] = 32'd103;
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("bp_rsp_valid_%0d", r), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_rsp_result_%0d", r), rsp_result, exp_res[r]);
            tick();
            req_valid = 2'b00;
        end
        chk("bp_no_dup", 32'(rsp_valid), 32'd0);

        // ---- reset mid-flight: fill S1 and S2 from requester 1 ----
        rsp_ready = 1'b0;
        set_req(1, 32'd7, 32'd1, 4'd0);
        req_valid = 2'b10;
        tick();
        tick();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mid_rsp_id", 32'(rsp_id), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_rsp_%0d", i), 32'(rsp_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
